multibank_read_scheduler: RTL and testbench

Read-side controller for the multi-bank BRAM array. It accepts a burst command with a base address and a word count, and issues lockstep reads on port B of every enabled bank. It collects the returned rows into a credit-protected output FIFO and presents them as a valid/ready stream with last-beat marking. It sits between the KAN layer sequencer, which issues commands, and the coefficient datapath, which consumes rows of BANKS×WIDTH bits.

---
 rtl/multibank_read_scheduler_pkg.sv | 19 +
 rtl/multibank_read_scheduler_rd_row_fifo.sv | 56 +++++
 rtl/multibank_read_scheduler.sv | 176 +++++++++++++++++
 tb/tb_multibank_read_scheduler.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multibank_read_scheduler_pkg.sv
// Shared types and helpers for the multi-bank read scheduler.
// Optional cmd_mask feature is enabled by defining MULTIBANK_RDSCHED_MASK_EN.
package multibank_read_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Ceiling log2 with a floor of 1 so a one-word bank still gets an address bit.
    function automatic int log2_ceil(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/multibank_read_scheduler_rd_row_fifo.sv
// Synchronous row FIFO; head entry is visible combinationally from storage registers.
// count_o includes the head entry and feeds the read-issue credit check.
module rd_row_fifo #(
    parameter int W     = 65,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [W-1:0]             din_i,
    input  logic                     pop_i,
    output logic [W-1:0]             dout_o,
    output logic                     valid_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign do_push = push_i && (count_q != CNT_W'(DEPTH));
    assign do_pop  = pop_i && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

endmodule

// File: rtl/multibank_read_scheduler.sv
// Burst read scheduler: lockstep port-B reads across banks into a credit-protected row FIFO.
// Define MULTIBANK_RDSCHED_MASK_EN to add a per-command bank mask input (cmd_mask).
module multibank_read_scheduler
    import multibank_read_scheduler_pkg::*;
#(
    parameter int BANKS      = 4,
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 256,
    parameter int ADDR       = log2_ceil(DEPTH),
    parameter int LEN_W      = ADDR + 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [ADDR-1:0]        cmd_addr,
    input  logic [LEN_W-1:0]       cmd_len,
`ifdef MULTIBANK_RDSCHED_MASK_EN
    input  logic [BANKS-1:0]       cmd_mask,
`endif
    output logic [BANKS-1:0]       enb,
    output logic [BANKS*ADDR-1:0]  addrb,
    input  logic [BANKS*WIDTH-1:0] doutb,
    input  logic [BANKS-1:0]       validb,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [BANKS*WIDTH-1:0] m_data,
    output logic                   m_last,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int ROW_W = BANKS * WIDTH;

    state_e            state_q, state_d;
    logic [ADDR-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d, len_q, len_d, push_cnt_q, push_cnt_d;
    logic [BANKS-1:0]  mask_q, mask_d;
    logic [CNT_W-1:0]  inflight_q, inflight_d;
    logic              err_q, err_d, done_q, done_d, last_acc_q, last_acc_d;

    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_valid;
    logic [ROW_W:0]    fifo_dout, push_row;
    logic [ROW_W-1:0]  row_masked;
    logic [BANKS-1:0]  cmd_mask_w, vb_en;
    logic              cmd_fire, credit_ok, issue, capture_gate, push, partial, pop, last_hs;

`ifdef MULTIBANK_RDSCHED_MASK_EN
    assign cmd_mask_w = cmd_mask;
`else
    assign cmd_mask_w = '1;
`endif

    assign cmd_ready = (state_q == ST_IDLE) && !rst;
    assign cmd_fire  = cmd_valid && cmd_ready;

    // Rows already in the FIFO plus reads still in flight may never exceed FIFO space.
    assign credit_ok = ({1'b0, inflight_q} + {1'b0, fifo_count}) < (CNT_W + 1)'(FIFO_DEPTH);
    assign issue     = (state_q == ST_ISSUE) && credit_ok;

    // Gating on inflight drops stale bank responses that land after a reset.
    assign capture_gate = (inflight_q != '0);
    assign vb_en        = validb & mask_q;
    assign push         = capture_gate && (mask_q != '0) && (vb_en == mask_q);
    assign partial      = capture_gate && (vb_en != '0) && (vb_en != mask_q);
    assign pop          = fifo_valid && m_ready;
    assign last_hs      = pop && fifo_dout[ROW_W];

    assign push_row = {(push_cnt_q + LEN_W'(1)) == len_q, row_masked};

    genvar gi;
    generate
        for (gi = 0; gi < BANKS; gi++) begin : g_lane
            assign enb[gi]                        = issue && mask_q[gi];
            assign addrb[gi*ADDR +: ADDR]         = issue ? addr_q : '0;
            assign row_masked[gi*WIDTH +: WIDTH]  = mask_q[gi] ? doutb[gi*WIDTH +: WIDTH] : '0;
            assign m_data[gi*WIDTH +: WIDTH]      = fifo_valid ? fifo_dout[gi*WIDTH +: WIDTH] : '0;
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        len_d      = len_q;
        mask_d     = mask_q;
        done_d     = 1'b0;
        err_d      = err_q | partial;
        inflight_d = inflight_q + CNT_W'(issue) - CNT_W'(push);
        push_cnt_d = push ? (push_cnt_q + LEN_W'(1)) : push_cnt_q;
        last_acc_d = last_acc_q | last_hs;
        case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    if ((cmd_len == '0) || (cmd_mask_w == '0)) begin
                        done_d = 1'b1;
                    end else begin
                        addr_d     = cmd_addr;
                        rem_d      = cmd_len;
                        len_d      = cmd_len;
                        mask_d     = cmd_mask_w;
                        push_cnt_d = '0;
                        last_acc_d = 1'b0;
                        state_d    = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (issue) begin
                    addr_d = (addr_q == ADDR'(DEPTH - 1)) ? '0 : addr_q + ADDR'(1);
                    rem_d  = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Finish in the cycle the last row is accepted so done lands one cycle later.
                if ((last_acc_q || last_hs) && (inflight_q == '0) &&
                    ((fifo_count - CNT_W'(pop)) == '0)) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            len_q      <= '0;
            mask_q     <= '0;
            inflight_q <= '0;
            push_cnt_q <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            last_acc_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            len_q      <= len_d;
            mask_q     <= mask_d;
            inflight_q <= inflight_d;
            push_cnt_q <= push_cnt_d;
            err_q      <= err_d;
            done_q     <= done_d;
            last_acc_q <= last_acc_d;
        end
    end

    rd_row_fifo #(
        .W     (ROW_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (push_row),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .valid_o (fifo_valid),
        .count_o (fifo_count)
    );

    assign m_valid = fifo_valid;
    assign m_last  = fifo_valid && fifo_dout[ROW_W];
    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_multibank_read_scheduler.sv
// Directed bench for multibank_read_scheduler with a one-cycle-latency BRAM model per bank.
// Mask checks are compiled in when MULTIBANK_RDSCHED_MASK_EN is defined.
module tb_multibank_read_scheduler;
    localparam int BANKS      = 4;
    localparam int WIDTH      = 16;
    localparam int DEPTH      = 256;
    localparam int ADDR       = 8;
    localparam int LEN_W      = 9;
    localparam int FIFO_DEPTH = 8;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [ADDR-1:0]        cmd_addr;
    logic [LEN_W-1:0]       cmd_len;
    logic [BANKS-1:0]       cmd_mask;
    logic [BANKS-1:0]       enb;
    logic [BANKS*ADDR-1:0]  addrb;
    logic [BANKS*WIDTH-1:0] doutb;
    logic [BANKS-1:0]       validb;
    logic                   m_valid;
    logic                   m_ready;
    logic [BANKS*WIDTH-1:0] m_data;
    logic                   m_last;
    logic                   busy;
    logic                   done;
    logic                   err;

    logic [BANKS-1:0]       vb_model;
    logic                   force_en;
    logic [BANKS-1:0]       force_vb;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    multibank_read_scheduler #(
        .BANKS(BANKS), .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR(ADDR),
        .LEN_W(LEN_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
`ifdef MULTIBANK_RDSCHED_MASK_EN
        .cmd_mask(cmd_mask),
`endif
        .enb(enb), .addrb(addrb), .doutb(doutb), .validb(validb),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy), .done(done), .err(err)
    );

    function automatic logic [WIDTH-1:0] bank_word(input int b, input int a);
        return WIDTH'(((b + 1) << 12) | (a & 12'hFFF));
    endfunction

    function automatic logic [63:0] exp_row(input int a, input logic [BANKS-1:0] m);
        logic [63:0] r;
        r = '0;
        for (int b = 0; b < BANKS; b++) if (m[b]) r[b*WIDTH +: WIDTH] = bank_word(b, a);
        return r;
    endfunction

    // BRAM model: registered read, one cycle latency, never reset.
    always @(posedge clk) begin
        for (int b = 0; b < BANKS; b++) begin
            vb_model[b] <= enb[b];
            if (enb[b]) doutb[b*WIDTH +: WIDTH] <= bank_word(b, int'(addrb[b*ADDR +: ADDR]));
        end
    end
    assign validb = force_en ? force_vb : vb_model;

    int          cyc = 0;
    int          issued, accepted, max_out, done_cnt, done_cyc, last_hs_cyc, first_mv;
    int          addr_log[$];
    int          enb_cyc[$];
    logic [63:0] rx_data[$];
    logic        rx_last[$];

    always @(posedge clk) begin
        cyc++;
        if (enb != '0) begin
            addr_log.push_back(int'(addrb[ADDR-1:0]));
            enb_cyc.push_back(cyc);
            issued++;
        end
        if (m_valid && first_mv < 0) first_mv = cyc;
        if (m_valid && m_ready) begin
            rx_data.push_back(64'(m_data));
            rx_last.push_back(m_last);
            accepted++;
            if (m_last) last_hs_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (issued - accepted > max_out) max_out = issued - accepted;
    end

    task automatic clear_log();
        addr_log.delete(); enb_cyc.delete(); rx_data.delete(); rx_last.delete();
        issued = 0; accepted = 0; max_out = 0; done_cnt = 0;
        done_cyc = -1; last_hs_cyc = -1; first_mv = -1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offers a command, holds it until accepted, and returns at the negedge after the handshake.
    task automatic send(input int a, input int len);
        int t;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_addr  = ADDR'(a);
        cmd_len   = LEN_W'(len);
        t = 0;
        while (!cmd_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int t;
        t = 0;
        while (!done && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_done_seen"}, 64'(done), 64'd1);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    task automatic check_burst(input string tag, input int base, input int n, input logic [BANKS-1:0] m);
        int sz;
        sz = rx_data.size();
        chk({tag, "_rows"}, 64'(sz), 64'(n));
        chk({tag, "_issues"}, 64'(addr_log.size()), 64'(n));
        for (int i = 0; i < n && i < sz && i < addr_log.size(); i++) begin
            chk($sformatf("%s_addr%0d", tag, i), 64'(addr_log[i]), 64'((base + i) % DEPTH));
            chk($sformatf("%s_data%0d", tag, i), rx_data[i], exp_row((base + i) % DEPTH, m));
            chk($sformatf("%s_last%0d", tag, i), 64'(rx_last[i]), 64'(i == n - 1));
        end
        chk({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
        chk({tag, "_busy_after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int t;
        rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_mask = '1;
        m_ready = 1'b0; force_en = 1'b0; force_vb = '0;
        clear_log();
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_enb", 64'(enb), 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("post_rst_outs", 64'({addrb, m_valid, m_last, busy, done, err}), 64'd0);

        // Basic burst: addresses 10..14, one row per cycle.
        clear_log();
        m_ready = 1'b1;
        send(10, 5);
        chk("b1_first_enb", 64'(enb), 64'hF);
        chk("b1_first_addr", 64'(addrb), 64'h0A0A0A0A);
        chk("b1_busy", 64'(busy), 64'd1);
        chk("b1_cmd_ready_low", 64'(cmd_ready), 64'd0);
        wait_done("b1", 50);
        check_burst("b1", 10, 5, 4'hF);
        for (int i = 1; i < enb_cyc.size(); i++)
            chk($sformatf("b1_back2back%0d", i), 64'(enb_cyc[i] - enb_cyc[i-1]), 64'd1);
        chk("b1_first_mvalid", 64'(first_mv - enb_cyc[0]), 64'd2);
        chk("b1_done_after_last", 64'(done_cyc - last_hs_cyc), 64'd1);

        // Address wrap at the top of the bank.
        clear_log();
        send(254, 4);
        wait_done("wrap", 50);
        check_burst("wrap", 254, 4, 4'hF);

        // Backpressure: issue must stall at FIFO_DEPTH committed rows.
        clear_log();
        m_ready = 1'b0;
        send(100, 20);
        repeat (30) @(negedge clk);
        chk("bp_issued_stall", 64'(issued), 64'd8);
        chk("bp_rx_during_stall", 64'(rx_data.size()), 64'd0);
        chk("bp_mvalid", 64'(m_valid), 64'd1);
        m_ready = 1'b1;
        wait_done("bp", 200);
        check_burst("bp", 100, 20, 4'hF);
        chk("bp_max_outstanding", 64'(max_out <= FIFO_DEPTH), 64'd1);

        // Zero-length command.
        clear_log();
        send(5, 0);
        chk("zl_done", 64'(done), 64'd1);
        chk("zl_busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("zl_done_pulse", 64'(done), 64'd0);
        chk("zl_no_enb", 64'(issued), 64'd0);

        // Reset in the middle of a 10-row burst.
        clear_log();
        send(40, 10);
        t = 0;
        while (rx_data.size() < 2 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("mr_rows_before_rst", 64'(rx_data.size()), 64'd2);
        rst = 1'b1;
        @(negedge clk);
        chk("mr_cmd_ready_in_rst", 64'(cmd_ready), 64'd0);
        chk("mr_outs", 64'({enb, addrb, m_valid, m_last, busy, done, err}), 64'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        clear_log();
        send(60, 2);
        wait_done("mr", 50);
        repeat (3) @(negedge clk);
        check_burst("mr", 60, 2, 4'hF);

`ifdef MULTIBANK_RDSCHED_MASK_EN
        clear_log();
        cmd_mask = 4'b0101;
        send(20, 2);
        chk("mask_enb", 64'(enb), 64'h5);
        wait_done("mask", 50);
        check_burst("mask", 20, 2, 4'b0101);
        clear_log();
        cmd_mask = 4'b0000;
        send(30, 3);
        chk("mask0_done", 64'(done), 64'd1);
        @(negedge clk);
        chk("mask0_no_enb", 64'(issued), 64'd0);
        cmd_mask = 4'b0101;
`endif

        // Partial validb across enabled banks raises the sticky error and pushes nothing.
        clear_log();
        force_en = 1'b1;
        force_vb = 4'b0001;
        send(70, 1);
        t = 0;
        while (!err && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk("err_set", 64'(err), 64'd1);
        repeat (3) @(negedge clk);
        chk("err_sticky", 64'(err), 64'd1);
        chk("err_no_push", 64'(m_valid), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        force_en = 1'b0;
        rst = 1'b0;
        #1;
        chk("err_cleared", 64'(err), 64'd0);
        chk("err_cmd_ready", 64'(cmd_ready), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
